pipeline_ctrl: RTL

//  Parametrised pipeline control for the microcoded RV32 core: PC sequencing, microcode/instruction-data shift pipeline,

---
 rtl/pipeline_ctrl_if.sv | 44 ++++
 rtl/pipeline_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Bus between pipeline_ctrl (master) and the decoder/datapath (slave).
// Optional perf counter outputs exist only when PIPE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if #(
  parameter int IDATA_W = 25
);
  // Handshake: there is no valid/ready pair. stall=1 means the controller did not accept s0
  // this cycle and the decoder must hold si/s0. flush=1 means the decoder must squash si/s0.
  // fetch_valid=0 means the word at pc is not usable and is refetched next cycle.
  logic [31:0]        ucode_s0;
  logic [IDATA_W-1:0] idata_s0;
  logic [31:0]        jump_target;
  logic [31:0]        reg_out_a;
  logic [31:0]        reg_out_b;
  logic [29:0]        pc;
  logic [29:0]        pc_br;
  logic [31:0]        ucode_s1;
  logic [31:0]        ucode_br;
  logic [31:0]        ucode_wb;
  logic [IDATA_W-1:0] idata_wb;
  logic               stall;
  logic               flush;
  logic               fetch_valid;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]        perf_stall;
  logic [31:0]        perf_flush;
  logic [31:0]        perf_retire;
`endif

  modport master (
    input  ucode_s0, idata_s0, jump_target, reg_out_a, reg_out_b,
    output pc, pc_br, ucode_s1, ucode_br, ucode_wb, idata_wb, stall, flush, fetch_valid
`ifdef PIPE_CTRL_PERF_EN
    , output perf_stall, perf_flush, perf_retire
`endif
  );

  modport slave (
    output ucode_s0, idata_s0, jump_target, reg_out_a, reg_out_b,
    input  pc, pc_br, ucode_s1, ucode_br, ucode_wb, idata_wb, stall, flush, fetch_valid
`ifdef PIPE_CTRL_PERF_EN
    , input perf_stall, perf_flush, perf_retire
`endif
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline control for the microcoded RV32 core: PC sequencing, stage shift, hazard stall, branch flush.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush/retire counters.
module pipeline_ctrl #(
  parameter int          DEPTH    = 3,      // legal 3..6
  parameter int          BR_STAGE = 2,      // 2 <= BR_STAGE < DEPTH
  parameter logic [29:0] RESET_PC = 30'h0,
  parameter int          IDATA_W  = 25
) (
  input  logic           clk,
  input  logic           rst_n,
  pipeline_ctrl_if.master bus
);

  logic [31:0]        ucode_q [1:DEPTH];
  logic [31:0]        ucode_d [1:DEPTH];
  logic [IDATA_W-1:0] idata_q [1:DEPTH];
  logic [IDATA_W-1:0] idata_d [1:DEPTH];
  logic [29:0]        pcs_q   [1:DEPTH];
  logic [29:0]        pcs_d   [1:DEPTH];
  logic               taken_q [2:DEPTH];
  logic               taken_d [2:DEPTH];
  logic [29:0]        pc_q, pc_d;
  logic               dep, flush, stall, fetch_hold;
  logic               unused_jt;

  assign unused_jt = ^bus.jump_target[1:0];

  function automatic logic cond_met(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0:    cond_met = 1'b0;
      3'd1:    cond_met = (a == b);
      3'd2:    cond_met = (a != b);
      3'd3:    cond_met = ($signed(a) < $signed(b));
      3'd4:    cond_met = ($signed(a) >= $signed(b));
      3'd5:    cond_met = (a < b);
      3'd6:    cond_met = (a >= b);
      default: cond_met = 1'b1;
    endcase
  endfunction

  // A writer of x0 never creates a dependency.
  always_comb begin
    dep = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (ucode_q[k][16] && (idata_q[k][4:0] != 5'd0) &&
          ((bus.ucode_s0[0] && (bus.idata_s0[12:8]  == idata_q[k][4:0])) ||
           (bus.ucode_s0[1] && (bus.idata_s0[17:13] == idata_q[k][4:0]))))
        dep = 1'b1;
    end
  end

  always_comb begin
    flush      = ucode_q[BR_STAGE][14] & taken_q[BR_STAGE];
    stall      = dep & ~flush;
    fetch_hold = ucode_q[BR_STAGE][15];

    ucode_d[1] = (stall || flush) ? 32'd0 : bus.ucode_s0;
    idata_d[1] = (stall || flush) ? '0 : bus.idata_s0;
    pcs_d[1]   = (stall || flush) ? 30'd0 : pc_q;
    for (int k = 2; k <= DEPTH; k++) begin
      ucode_d[k] = ucode_q[k-1];
      idata_d[k] = idata_q[k-1];
      pcs_d[k]   = pcs_q[k-1];
    end
    // The condition is resolved as the instruction leaves s1 and then rides along with it.
    taken_d[2] = cond_met(ucode_q[1][31:29], bus.reg_out_a, bus.reg_out_b);
    for (int k = 3; k <= DEPTH; k++) taken_d[k] = taken_q[k-1];

    // Younger instructions in s1..s(BR_STAGE-1) are killed as they move up one stage.
    if (flush) begin
      for (int k = 2; k <= BR_STAGE; k++) begin
        ucode_d[k] = 32'd0;
        idata_d[k] = '0;
        pcs_d[k]   = 30'd0;
        taken_d[k] = 1'b0;
      end
    end

    if (flush)                   pc_d = bus.jump_target[31:2];
    else if (stall || fetch_hold) pc_d = pc_q;
    else                         pc_d = pc_q + 30'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      for (int k = 1; k <= DEPTH; k++) begin
        ucode_q[k] <= 32'd0;
        idata_q[k] <= '0;
        pcs_q[k]   <= 30'd0;
      end
      for (int k = 2; k <= DEPTH; k++) taken_q[k] <= 1'b0;
    end else begin
      pc_q <= pc_d;
      for (int k = 1; k <= DEPTH; k++) begin
        ucode_q[k] <= ucode_d[k];
        idata_q[k] <= idata_d[k];
        pcs_q[k]   <= pcs_d[k];
      end
      for (int k = 2; k <= DEPTH; k++) taken_q[k] <= taken_d[k];
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_br       = pcs_q[BR_STAGE];
  assign bus.ucode_s1    = ucode_q[1];
  assign bus.ucode_br    = ucode_q[BR_STAGE];
  assign bus.ucode_wb    = ucode_q[DEPTH];
  assign bus.idata_wb    = idata_q[DEPTH];
  assign bus.stall       = stall;
  assign bus.flush       = flush;
  assign bus.fetch_valid = ~fetch_hold;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_retire_q, perf_retire_d;

  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_flush_d  = perf_flush_q;
    perf_retire_d = perf_retire_q;
    if (stall && (perf_stall_q != 32'hFFFFFFFF))                 perf_stall_d  = perf_stall_q + 32'd1;
    if (flush && (perf_flush_q != 32'hFFFFFFFF))                 perf_flush_d  = perf_flush_q + 32'd1;
    if ((ucode_q[DEPTH] != 32'd0) && (perf_retire_q != 32'hFFFFFFFF)) perf_retire_d = perf_retire_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q  <= 32'd0;
      perf_flush_q  <= 32'd0;
      perf_retire_q <= 32'd0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_flush_q  <= perf_flush_d;
      perf_retire_q <= perf_retire_d;
    end
  end

  assign bus.perf_stall  = perf_stall_q;
  assign bus.perf_flush  = perf_flush_q;
  assign bus.perf_retire = perf_retire_q;
`endif

endmodule
